pwm_capture: RTL and testbench

Measures an incoming active-low PWM waveform (the LED-drive format: low for the duty portion, high for the rest). Every period it reports the period length and the low time in CLK cycles. It also recovers the ramp direction of a breathing pattern and flags a stuck input (0 % or 100 % duty). It sits on the input side of the RGB chain: it loops back the generated PWM for self-check, or decodes an external dimmer signal into a duty value.

---
 rtl/pwm_capture.sv | 101 ++++++++++
 tb/tb_pwm_capture.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Measures period and low time of an active-low PWM input, tracks breathing ramp
// direction and flags a stuck input after TIMEOUT cycles without a falling edge.
module pwm_capture #(
    parameter int W       = 25,
    parameter int TIMEOUT = 4800
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         PWM_IN,
    output logic [W-1:0] PERIOD,
    output logic [W-1:0] LOW_TIME,
    output logic         VALID,
    output logic         DIR,
    output logic         STUCK,
    output logic         STUCK_LVL
);
    localparam logic [W-1:0] TMO    = W'(TIMEOUT);
    localparam logic [W-1:0] TMO_M1 = W'(TIMEOUT - 1);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t       state_q;
    logic         s1_q, s2_q, s3_q;
    logic [W-1:0] pcnt_q, lcnt_q, pcnt_d, lcnt_d;
    logic [W-1:0] period_q, low_q, mag;
    logic         valid_q, dir_q, dir_d, stuck_q, lvl_q, first_q;
    logic         fe, timeout;

    always_comb begin
        fe      = s3_q & ~s2_q;
        pcnt_d  = pcnt_q;
        lcnt_d  = lcnt_q;
        if (fe) begin
            pcnt_d = W'(1);
            lcnt_d = W'(1);
        end else begin
            if (pcnt_q < TMO)           pcnt_d = pcnt_q + W'(1);
            if (!s2_q && lcnt_q < TMO)  lcnt_d = lcnt_q + W'(1);
        end
        // fe in the same cycle as the timeout wins
        timeout = !fe && (pcnt_q == TMO_M1);

        mag   = (lcnt_q > low_q) ? (lcnt_q - low_q) : (low_q - lcnt_q);
        dir_d = dir_q;
        // a jump larger than half a period is the ramp wrapping, not a direction change
        if (!first_q && (lcnt_q != low_q) && (mag <= (pcnt_q >> 1)))
            dir_d = (lcnt_q > low_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            pcnt_q   <= '0;
            lcnt_q   <= '0;
            period_q <= '0;
            low_q    <= '0;
            valid_q  <= 1'b0;
            dir_q    <= 1'b0;
            stuck_q  <= 1'b0;
            lvl_q    <= 1'b1;
            first_q  <= 1'b0;
        end else begin
            s1_q    <= PWM_IN;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pcnt_q  <= pcnt_d;
            lcnt_q  <= lcnt_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (fe) begin
                    state_q <= MEAS;
                    first_q <= 1'b1;
                    stuck_q <= 1'b0;
                end
                MEAS: if (fe) begin
                    period_q <= pcnt_q;
                    low_q    <= lcnt_q;
                    valid_q  <= 1'b1;
                    dir_q    <= dir_d;
                    first_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (timeout) begin
                stuck_q <= 1'b1;
                lvl_q   <= s2_q;
                state_q <= IDLE;
            end
        end
    end

    assign PERIOD    = period_q;
    assign LOW_TIME  = low_q;
    assign VALID     = valid_q;
    assign DIR       = dir_q;
    assign STUCK     = stuck_q;
    assign STUCK_LVL = lvl_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed plus randomized PWM segments checked against a cycle-indexed reference
// model built from input fall times and low-phase lengths.
module tb_pwm_capture;
    localparam int W   = 25;
    localparam int TMO = 4800;

    logic         CLK = 1'b0, RST = 1'b1, PWM_IN = 1'b1;
    logic [W-1:0] PERIOD, LOW_TIME;
    logic         VALID, DIR, STUCK, STUCK_LVL;

    pwm_capture #(.W(W), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .PWM_IN(PWM_IN),
        .PERIOD(PERIOD), .LOW_TIME(LOW_TIME), .VALID(VALID),
        .DIR(DIR), .STUCK(STUCK), .STUCK_LVL(STUCK_LVL)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // one entry per input fall: edge at which it is seen, and the period/low it closes
    typedef struct {int due; int per; int low;} ev_t;
    ev_t evq[$];

    int ncmp = 0, nerr = 0;
    bit meas = 0, first = 0;
    int e_per = 0, e_low = 0;
    bit e_dir = 0, e_stk = 0, e_lvl = 1, e_vld = 0;
    int last_fe = 0, last_drop = 0, low_len = 0;
    bit p1 = 1, p2 = 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all(string pfx);
        chk({pfx, "_period"}, PERIOD, e_per);
        chk({pfx, "_low"}, LOW_TIME, e_low);
        chk({pfx, "_dir"}, DIR, e_dir);
        chk({pfx, "_lvl"}, STUCK_LVL, e_lvl);
    endtask

    // called at the falling clock edge after posedge number cyc
    task automatic check_cycle();
        int  n;
        bit  tout;
        ev_t e;
        n     = cyc;
        tout  = 0;
        e_vld = 0;
        if (evq.size() > 0 && evq[0].due == n) begin
            e = evq.pop_front();
            last_fe = n;
            if (meas) begin
                int d;
                d = e.low - e_low;
                if (!first && d != 0 && ((d < 0) ? -d : d) <= e.per / 2) e_dir = (d > 0);
                first = 0;
                e_per = e.per;
                e_low = e.low;
                e_vld = 1;
            end else begin
                meas  = 1;
                first = 1;
                e_stk = 0;
            end
        end else if (n == last_fe + TMO - 1) begin
            e_stk = 1;
            e_lvl = p2;
            meas  = 0;
            tout  = 1;
        end
        chk("valid", VALID, e_vld);
        chk("stuck", STUCK, e_stk);
        if (e_vld)             chk_all("meas");
        else if (tout)         chk_all("timeout");
        else if (n % 64 == 0)  chk_all("hold");
    endtask

    task automatic drive(bit v);
        @(negedge CLK);
        check_cycle();
        if (!v && PWM_IN) begin
            evq.push_back('{due: cyc + 3, per: cyc - last_drop, low: low_len});
            last_drop = cyc;
            low_len   = 0;
        end
        if (!v) low_len++;
        p2 = p1;
        p1 = PWM_IN;
        PWM_IN = v;
    endtask

    task automatic seg(int l, int h);
        repeat (l) drive(1'b0);
        repeat (h) drive(1'b1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        PWM_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        evq.delete();
        meas = 0; first = 0;
        e_per = 0; e_low = 0; e_dir = 0; e_stk = 0; e_lvl = 1;
        last_fe = cyc + 1; last_drop = cyc; low_len = 0;
        p1 = 1; p2 = 1;
        chk("rst_valid", VALID, 1'b0);
        chk("rst_stuck", STUCK, 1'b0);
        chk_all("rst");
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        do_reset();

        // steady 2400/600
        repeat (3) seg(600, 1800);

        // rising ramp, then falling ramp
        for (int l = 100; l <= 103; l++) seg(l, 2400 - l);
        for (int l = 500; l >= 498; l--) seg(l, 2400 - l);

        // large jumps: 498->2398 and 2399->1 are wraps and must hold DIR
        seg(2398, 2);
        seg(2399, 1);
        seg(1, 2399);
        seg(2, 2398);

        // random waveforms
        repeat (6) seg(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));

        // 0 % duty: stuck high, then resume
        seg(600, 5000);
        repeat (3) seg(600, 1800);

        // 100 % duty: stuck low, then resume
        seg(5200, 100);
        repeat (2) seg(600, 1800);

        // reset during the high phase discards the partial period
        seg(600, 1000);
        do_reset();
        repeat (3) seg(600, 1800);
        drive(1'b0);
        repeat (6) drive(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
